// File: rtl/ecc_131_err_ctrl.sv
// ecc_131_err_ctrl: control, event monitoring and self-test sequencing for a
// 131-bit ECC fault-detect datapath on a FIFO read path.
`default_nettype none

module ecc_131_err_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int TMO_WIDTH  = 12,
  parameter int TMO_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_detc_en,
  input  logic                 cfg_bypass,
  input  logic [CNT_WIDTH-1:0] cfg_sbit_thr,
  input  logic                 cfg_clr,
  input  logic                 st_start,
  input  logic                 rd_vld,
  input  logic                 sbit_err,
  input  logic                 dbit_err,
  input  logic                 ecc_fault,
  output logic                 ecc_fault_detc_en,
  output logic                 ecc_bypass,
  output logic                 inj_en,
  output logic                 inj_dbit,
  output logic [CNT_WIDTH-1:0] sbit_cnt,
  output logic [CNT_WIDTH-1:0] dbit_cnt,
  output logic [CNT_WIDTH-1:0] fault_cnt,
  output logic [2:0]           sts_sticky,
  output logic                 irq,
  output logic                 st_busy,
  output logic                 st_done,
  output logic                 st_pass
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SB_ARM = 3'd1;
  localparam logic [2:0] S_SB_CHK = 3'd2;
  localparam logic [2:0] S_DB_ARM = 3'd3;
  localparam logic [2:0] S_DB_CHK = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic                 pass_sb_q, pass_sb_d;
  logic                 pass_db_q, pass_db_d;
  logic                 inj_en_q, inj_en_d;
  logic                 inj_dbit_q, inj_dbit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 detc_q, detc_d;
  logic                 byp_q, byp_d;
  logic [CNT_WIDTH-1:0] sbit_cnt_q, sbit_cnt_d;
  logic [CNT_WIDTH-1:0] dbit_cnt_q, dbit_cnt_d;
  logic [CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
  logic [2:0]           sticky_q, sticky_d;
  logic                 irq_q, irq_d;
  logic                 in_test;
  logic                 mon_vld;
  logic                 thr_hit;

  assign in_test = (state_q != S_IDLE);
  assign mon_vld = rd_vld & ~in_test;

  // Self-test sequencer; inj_en is registered so it is asserted for the whole ARM state.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pass_sb_d  = pass_sb_q;
    pass_db_d  = pass_db_q;
    inj_en_d   = inj_en_q;
    inj_dbit_d = inj_dbit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    case (state_q)
      S_IDLE: begin
        if (st_start) begin
          state_d    = S_SB_ARM;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          tmo_d      = '0;
          inj_en_d   = 1'b1;
          inj_dbit_d = 1'b0;
          pass_sb_d  = 1'b0;
          pass_db_d  = 1'b0;
        end
      end
      S_SB_ARM, S_DB_ARM: begin
        if (rd_vld) begin
          state_d  = (state_q == S_SB_ARM) ? S_SB_CHK : S_DB_CHK;
          inj_en_d = 1'b0;
          if (state_q == S_SB_ARM) pass_sb_d = sbit_err & ~dbit_err & ~ecc_fault;
          else                     pass_db_d = dbit_err & ~ecc_fault;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_DONE;
          inj_en_d   = 1'b0;
          inj_dbit_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pass_d     = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
      S_SB_CHK: begin
        state_d    = S_DB_ARM;
        tmo_d      = '0;
        inj_en_d   = 1'b1;
        inj_dbit_d = 1'b1;
      end
      S_DB_CHK: begin
        state_d    = S_DONE;
        inj_dbit_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        pass_d     = pass_sb_q & pass_db_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    detc_d = in_test | cfg_detc_en;
    byp_d  = ~in_test & cfg_bypass;
  end

  // irq is judged on the post-update counts so it rises on the same edge as the event.
  always_comb begin
    sbit_cnt_d  = sbit_cnt_q;
    dbit_cnt_d  = dbit_cnt_q;
    fault_cnt_d = fault_cnt_q;
    sticky_d    = sticky_q;
    thr_hit     = 1'b0;
    irq_d       = irq_q;
    if (cfg_clr) begin
      sbit_cnt_d  = '0;
      dbit_cnt_d  = '0;
      fault_cnt_d = '0;
      sticky_d    = '0;
      irq_d       = 1'b0;
    end else begin
      if (mon_vld) begin
        if (sbit_err  && sbit_cnt_q  != CNT_MAX) sbit_cnt_d  = sbit_cnt_q  + CNT_WIDTH'(1);
        if (dbit_err  && dbit_cnt_q  != CNT_MAX) dbit_cnt_d  = dbit_cnt_q  + CNT_WIDTH'(1);
        if (ecc_fault && fault_cnt_q != CNT_MAX) fault_cnt_d = fault_cnt_q + CNT_WIDTH'(1);
        sticky_d = sticky_q | {ecc_fault, dbit_err, sbit_err};
      end
      thr_hit = (cfg_sbit_thr != '0) && (sbit_cnt_d >= cfg_sbit_thr);
      irq_d   = irq_q | sticky_d[2] | sticky_d[1] | thr_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      pass_sb_q   <= 1'b0;
      pass_db_q   <= 1'b0;
      inj_en_q    <= 1'b0;
      inj_dbit_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      detc_q      <= 1'b0;
      byp_q       <= 1'b0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
      sticky_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      pass_sb_q   <= pass_sb_d;
      pass_db_q   <= pass_db_d;
      inj_en_q    <= inj_en_d;
      inj_dbit_q  <= inj_dbit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      detc_q      <= detc_d;
      byp_q       <= byp_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      sticky_q    <= sticky_d;
      irq_q       <= irq_d;
    end
  end

  assign ecc_fault_detc_en = detc_q;
  assign ecc_bypass        = byp_q;
  assign inj_en            = inj_en_q;
  assign inj_dbit          = inj_dbit_q;
  assign sbit_cnt          = sbit_cnt_q;
  assign dbit_cnt          = dbit_cnt_q;
  assign fault_cnt         = fault_cnt_q;
  assign sts_sticky        = sticky_q;
  assign irq               = irq_q;
  assign st_busy           = busy_q;
  assign st_done           = done_q;
  assign st_pass           = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_ecc_131_err_ctrl.sv
// Randomized scoreboard bench for ecc_131_err_ctrl with a behavioural reference model.
`default_nettype none

module tb_ecc_131_err_ctrl;

  localparam int CW  = 16;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_detc_en = 1'b0, cfg_bypass = 1'b0, cfg_clr = 1'b0, st_start = 1'b0;
  logic [CW-1:0] cfg_sbit_thr = '0;
  logic          rd_vld = 1'b0, sbit_err = 1'b0, dbit_err = 1'b0, ecc_fault = 1'b0;
  logic          ecc_fault_detc_en, ecc_bypass, inj_en, inj_dbit;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [2:0]    sts_sticky;
  logic          irq, st_busy, st_done, st_pass;

  ecc_131_err_ctrl #(.CNT_WIDTH(CW), .TMO_WIDTH(12), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_detc_en(cfg_detc_en), .cfg_bypass(cfg_bypass),
    .cfg_sbit_thr(cfg_sbit_thr), .cfg_clr(cfg_clr), .st_start(st_start),
    .rd_vld(rd_vld), .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
    .ecc_fault_detc_en(ecc_fault_detc_en), .ecc_bypass(ecc_bypass),
    .inj_en(inj_en), .inj_dbit(inj_dbit), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .fault_cnt(fault_cnt), .sts_sticky(sts_sticky), .irq(irq), .st_busy(st_busy),
    .st_done(st_done), .st_pass(st_pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sb, db, fc;
    bit [2:0] sticky;
    bit irq, chk_ctl, detc, byp;
  } exp_t;

  exp_t sq[$];
  bit   st_q[$];
  int   checks = 0, errors = 0, done_cnt = 0;

  // reference model state
  int m_sb = 0, m_db = 0, m_fc = 0;
  bit [2:0] m_st = '0;
  bit m_irq = 0, m_test = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (st_done) begin
        done_cnt++;
        if (st_q.size() == 0) check("unexpected_st_done", 32'(st_done), 32'd0);
        else check("st_pass", 32'(st_pass), 32'(st_q.pop_front()));
      end
      if (sq.size() > 0) begin
        e = sq.pop_front();
        check("sbit_cnt", 32'(sbit_cnt), 32'(e.sb));
        check("dbit_cnt", 32'(dbit_cnt), 32'(e.db));
        check("fault_cnt", 32'(fault_cnt), 32'(e.fc));
        check("sts_sticky", 32'(sts_sticky), 32'(e.sticky));
        check("irq", 32'(irq), 32'(e.irq));
        if (e.chk_ctl) begin
          check("detc_en", 32'(ecc_fault_detc_en), 32'(e.detc));
          check("bypass", 32'(ecc_bypass), 32'(e.byp));
        end
      end
    end
  end

  function automatic int sat_inc(input int v, input bit inc);
    return (inc && v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic cyc(input bit rd, input bit s, input bit d, input bit f,
                     input bit clr, input bit st);
    exp_t e;
    @(negedge clk);
    rd_vld = rd; sbit_err = s; dbit_err = d; ecc_fault = f; cfg_clr = clr; st_start = st;
    if (clr) begin
      m_sb = 0; m_db = 0; m_fc = 0; m_st = '0; m_irq = 0;
    end else begin
      if (rd && !m_test) begin
        m_sb = sat_inc(m_sb, s);
        m_db = sat_inc(m_db, d);
        m_fc = sat_inc(m_fc, f);
        m_st = m_st | {f, d, s};
      end
      if (m_st[2] || m_st[1] || (cfg_sbit_thr != 0 && m_sb >= int'(cfg_sbit_thr))) m_irq = 1;
    end
    e.sb = m_sb; e.db = m_db; e.fc = m_fc; e.sticky = m_st; e.irq = m_irq;
    e.chk_ctl = !m_test; e.detc = cfg_detc_en; e.byp = cfg_bypass;
    sq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // mode 0: correct datapath; 1: dbit phase reports sbit only; 2: no reads at all
  task automatic run_st(input int mode);
    int reads = 0, gap = 0, d0;
    bit rd, s, d;
    st_q.push_back(mode == 0);
    d0 = done_cnt;
    cyc(0, 0, 0, 0, 0, 1);
    m_test = 1;
    check("st_busy_start", 32'(st_busy), 32'd1);
    check("st_pass_cleared", 32'(st_pass), 32'd0);
    for (int n = 0; n < 200 && done_cnt == d0; n++) begin
      rd = 0; s = 0; d = 0;
      if (mode != 2 && reads < 2) begin
        gap++;
        if (gap == 3) begin
          gap = 0; rd = 1; reads++;
          check("inj_en_at_read", 32'(inj_en), 32'd1);
          check("inj_dbit_at_read", 32'(inj_dbit), 32'(reads == 2));
          check("test_detc_en", 32'(ecc_fault_detc_en), 32'd1);
          check("test_bypass", 32'(ecc_bypass), 32'd0);
          if (!inj_dbit || mode == 1) s = 1;
          else d = 1;
        end
      end
      cyc(rd, s, d, 0, 0, 0);
    end
    check("st_done_seen", 32'(done_cnt - d0), 32'd1);
    check("st_busy_end", 32'(st_busy), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    m_test = 0;
  endtask

  initial begin
    int d0;
    @(posedge clk);
    #1;
    check("rst_detc_en", 32'(ecc_fault_detc_en), 32'd0);
    check("rst_bypass", 32'(ecc_bypass), 32'd0);
    check("rst_inj_en", 32'(inj_en), 32'd0);
    check("rst_cnt", 32'({sbit_cnt, dbit_cnt}), 32'd0);
    check("rst_st", 32'({irq, st_busy, st_done, st_pass, sts_sticky}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cfg_detc_en = 1; cfg_bypass = 1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    cfg_sbit_thr = 5;
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0);
    check("irq_after_5", 32'(irq), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 1, 0);

    cfg_sbit_thr = 0;
    cyc(1, 0, 0, 1, 0, 0);
    check("irq_fault", 32'(irq), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) cfg_sbit_thr = CW'($urandom_range(0, 20));
      cfg_detc_en = 1'($urandom); cfg_bypass = 1'($urandom);
      cyc(1'($urandom), ($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 7) == 0,
          ($urandom % 40) == 0, 0);
    end

    cfg_sbit_thr = 0;
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 70000; i++) cyc(1, 1, 0, 0, 0, 0);
    check("sbit_sat", 32'(sbit_cnt), 32'hFFFF);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);

    cfg_detc_en = 0; cfg_bypass = 1;
    run_st(0);
    run_st(1);
    run_st(2);
    cyc(0, 0, 0, 0, 0, 0);

    // reset while the dbit phase is armed
    st_q.push_back(1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    m_test = 1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("db_arm_inj", 32'({inj_en, inj_dbit}), 32'd3);
    d0 = done_cnt;
    #3 rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(st_busy), 32'd0);
    check("rst_mid_inj", 32'(inj_en), 32'd0);
    check("rst_mid_cnt", 32'(sbit_cnt), 32'd0);
    sq.delete(); st_q.delete();
    m_sb = 0; m_db = 0; m_fc = 0; m_st = '0; m_irq = 0; m_test = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    run_st(0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
